// File: rtl/memaccess.sv
// Memory-stage load/store unit: one outstanding request on a req/addr_ok/data_ok
// SRAM-like bus, with strobes, lane replication, alignment checks and LL/SC link bit.
module memaccess (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        mem_allowin,
  input  logic [7:0]  ex_op,
  input  logic [1:0]  ex_access_sz,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_reg_d,
  input  logic [31:0] ex_exe_out,
  output logic        wb_valid,
  input  logic        wb_allowin,
  output logic [7:0]  wb_op,
  output logic [1:0]  wb_mm_access_sz,
  output logic [4:0]  wb_reg_d,
  output logic [31:0] wb_exe_out,
  output logic [31:0] wb_rdata,
  output logic        wb_ale,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_LDU = 8'h02;
  localparam logic [7:0] OP_LL  = 8'h03;
  localparam logic [7:0] OP_ST  = 8'h04;
  localparam logic [7:0] OP_SC  = 8'h05;

  localparam logic [1:0] ACCESS_SZ_BYTE = 2'd0;
  localparam logic [1:0] ACCESS_SZ_HALF = 2'd1;
  localparam logic [1:0] ACCESS_SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_nx;
  logic        llbit;
  logic        accept;
  logic        ex_load, ex_store, ex_mem, ex_ale, ex_bus;
  logic [3:0]  ex_wstrb;
  logic [31:0] ex_wdata_rep;
  logic        wb_load;

  always_comb begin
    mem_allowin  = (state == IDLE) || (state == DONE && wb_allowin);
    accept       = ex_valid && mem_allowin;
    ex_load      = (ex_op == OP_LD) || (ex_op == OP_LDU) || (ex_op == OP_LL);
    ex_store     = (ex_op == OP_ST) || (ex_op == OP_SC);
    ex_mem       = ex_load || ex_store;
    ex_ale       = ex_mem &&
                   (((ex_access_sz == ACCESS_SZ_HALF) && ex_addr[0]) ||
                    ((ex_access_sz == ACCESS_SZ_WORD) && (ex_addr[1:0] != 2'b00)));
    // A failed SC completes locally, just like a misaligned access.
    ex_bus       = ex_mem && !ex_ale && !((ex_op == OP_SC) && !llbit);
    wb_load      = (wb_op == OP_LD) || (wb_op == OP_LDU) || (wb_op == OP_LL);
    ex_wstrb     = 4'b1111;
    ex_wdata_rep = ex_wdata;
    case (ex_access_sz)
      ACCESS_SZ_BYTE: begin
        ex_wstrb     = 4'b0001 << ex_addr[1:0];
        ex_wdata_rep = {4{ex_wdata[7:0]}};
      end
      ACCESS_SZ_HALF: begin
        ex_wstrb     = 4'b0011 << {ex_addr[1], 1'b0};
        ex_wdata_rep = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = ex_bus ? REQ : DONE;
      REQ:  if (data_sram_addr_ok) state_nx = RESP;
      RESP: if (data_sram_data_ok) state_nx = DONE;
      DONE: begin
        if (accept)          state_nx = ex_bus ? REQ : DONE;
        else if (wb_allowin) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign wb_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      llbit           <= 1'b0;
      wb_op           <= '0;
      wb_mm_access_sz <= '0;
      wb_reg_d        <= '0;
      wb_exe_out      <= '0;
      wb_rdata        <= '0;
      wb_ale          <= 1'b0;
      data_sram_req   <= 1'b0;
      data_sram_wr    <= 1'b0;
      data_sram_size  <= '0;
      data_sram_wstrb <= '0;
      data_sram_addr  <= '0;
      data_sram_wdata <= '0;
    end else begin
      if (accept) begin
        wb_op           <= ex_op;
        wb_mm_access_sz <= ex_access_sz;
        wb_reg_d        <= ex_reg_d;
        wb_exe_out      <= ex_exe_out;
        wb_ale          <= ex_ale;
        wb_rdata        <= {31'b0, ex_bus && (ex_op == OP_SC)};
        data_sram_req   <= ex_bus;
        data_sram_wr    <= ex_bus && ex_store;
        data_sram_size  <= ex_access_sz;
        data_sram_wstrb <= (ex_bus && ex_store) ? ex_wstrb : 4'b0000;
        data_sram_addr  <= ex_addr;
        data_sram_wdata <= ex_wdata_rep;
      end
      if (state == REQ && data_sram_addr_ok) data_sram_req <= 1'b0;
      if (state == RESP && data_sram_data_ok) begin
        if (wb_load)         wb_rdata <= data_sram_rdata >> {data_sram_addr[1:0], 3'b000};
        if (wb_op == OP_LL)  llbit    <= 1'b1;
        if (wb_op == OP_SC)  llbit    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memaccess.sv
// Self-checking bench for memaccess: vector table plus hand sequences, wb results via scoreboard queue.
module tb_memaccess;

  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_LDU = 8'h02;
  localparam logic [7:0] OP_LL  = 8'h03;
  localparam logic [7:0] OP_ST  = 8'h04;
  localparam logic [7:0] OP_SC  = 8'h05;
  localparam logic [7:0] OP_ALU = 8'h20;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  logic        clk = 1'b0;
  logic        reset, ex_valid, mem_allowin, wb_valid, wb_allowin, wb_ale;
  logic [7:0]  ex_op, wb_op;
  logic [1:0]  ex_access_sz, wb_mm_access_sz, data_sram_size;
  logic [31:0] ex_addr, ex_wdata, ex_exe_out, wb_exe_out, wb_rdata;
  logic [4:0]  ex_reg_d, wb_reg_d;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

  memaccess dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .mem_allowin(mem_allowin),
    .ex_op(ex_op), .ex_access_sz(ex_access_sz), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_reg_d(ex_reg_d), .ex_exe_out(ex_exe_out), .wb_valid(wb_valid), .wb_allowin(wb_allowin),
    .wb_op(wb_op), .wb_mm_access_sz(wb_mm_access_sz), .wb_reg_d(wb_reg_d),
    .wb_exe_out(wb_exe_out), .wb_rdata(wb_rdata), .wb_ale(wb_ale),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned okdly;
    logic        bus;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] bwdata;
    logic [31:0] exp_rd;
    logic        ale;
  } vec_t;

  typedef struct {
    logic [7:0]  op;
    logic [1:0]  sz;
    logic [4:0]  rd;
    logic [31:0] eo;
    logic [31:0] rdata;
    logic        ale;
  } wb_t;

  wb_t         sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(input logic [7:0] op, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int unsigned okdly, input logic bus, input logic wr,
                              input logic [3:0] wstrb, input logic [31:0] bwdata,
                              input logic [31:0] exp_rd, input logic ale);
    vec_t v;
    v.op = op; v.sz = sz; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.okdly = okdly;
    v.bus = bus; v.wr = wr; v.wstrb = wstrb; v.bwdata = bwdata; v.exp_rd = exp_rd; v.ale = ale;
    return v;
  endfunction

  // Scoreboard consumer: one entry per writeback handoff.
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_allowin) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_wb", {24'b0, wb_op}, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_op", {24'b0, wb_op}, {24'b0, e.op});
        chk("wb_sz", {30'b0, wb_mm_access_sz}, {30'b0, e.sz});
        chk("wb_reg_d", {27'b0, wb_reg_d}, {27'b0, e.rd});
        chk("wb_exe_out", wb_exe_out, e.eo);
        chk("wb_rdata", wb_rdata, e.rdata);
        chk("wb_ale", {31'b0, wb_ale}, {31'b0, e.ale});
      end
    end
  end

  task automatic drive_ex(input vec_t v, input logic [4:0] rd, input logic [31:0] eo, input bit push);
    wb_t e;
    ex_valid = 1'b1; ex_op = v.op; ex_access_sz = v.sz; ex_addr = v.addr;
    ex_wdata = v.wdata; ex_reg_d = rd; ex_exe_out = eo;
    if (push) begin
      e.op = v.op; e.sz = v.sz; e.rd = rd; e.eo = eo; e.rdata = v.exp_rd; e.ale = v.ale;
      sb.push_back(e);
    end
  endtask

  // Entered just after the accept edge; returns at the negedge of the first wb_valid cycle.
  task automatic after_accept(input vec_t v);
    ex_valid = 1'b0;
    if (v.bus) begin
      for (int unsigned k = 0; k <= v.okdly; k++) begin
        data_sram_addr_ok = (k == v.okdly);
        @(negedge clk);
        chk("req", {31'b0, data_sram_req}, 32'd1);
        chk("wr", {31'b0, data_sram_wr}, {31'b0, v.wr});
        chk("size", {30'b0, data_sram_size}, {30'b0, v.sz});
        chk("wstrb", {28'b0, data_sram_wstrb}, {28'b0, v.wstrb});
        chk("addr", data_sram_addr, v.addr);
        chk("wdata", data_sram_wdata, v.bwdata);
        chk("wb_valid_early", {31'b0, wb_valid}, 32'd0);
        if (k == 0) chk("allowin_busy", {31'b0, mem_allowin}, 32'd0);
        @(posedge clk); #1;
      end
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = v.rdata;
      @(negedge clk);
      chk("req_drop", {31'b0, data_sram_req}, 32'd0);
      chk("wb_valid_early", {31'b0, wb_valid}, 32'd0);
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    chk("wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("req_idle", {31'b0, data_sram_req}, 32'd0);
  endtask

  task automatic do_op(input vec_t v, input logic [4:0] rd, input logic [31:0] eo);
    drive_ex(v, rd, eo, 1'b1);
    @(negedge clk);
    chk("allowin", {31'b0, mem_allowin}, 32'd1);
    @(posedge clk); #1;
    after_accept(v);
    @(posedge clk); #1;
  endtask

  vec_t vt[16];
  vec_t v1, v2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(OP_LD,  SZ_B, 32'h1003, 32'h0, 32'h80AABBCC, 0, 1, 0, 4'b0000, 32'h0, 32'h80, 0);
    vt[1]  = mk(OP_ST,  SZ_H, 32'h2002, 32'h1234ABCD, 32'hDEADBEEF, 4, 1, 1, 4'b1100, 32'hABCDABCD, 32'h0, 0);
    vt[2]  = mk(OP_LD,  SZ_W, 32'h3001, 32'h0, 32'h0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 1);
    vt[3]  = mk(OP_ST,  SZ_B, 32'h5001, 32'h000000A5, 32'h0, 0, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h0, 0);
    vt[4]  = mk(OP_ST,  SZ_B, 32'h5003, 32'hFFFFFF3C, 32'h0, 1, 1, 1, 4'b1000, 32'h3C3C3C3C, 32'h0, 0);
    vt[5]  = mk(OP_LD,  SZ_H, 32'h6002, 32'h0, 32'h12345678, 2, 1, 0, 4'b0000, 32'h0, 32'h1234, 0);
    vt[6]  = mk(OP_LDU, SZ_H, 32'h6000, 32'h0, 32'h12345678, 0, 1, 0, 4'b0000, 32'h0, 32'h12345678, 0);
    vt[7]  = mk(OP_LD,  SZ_W, 32'h7000, 32'h0, 32'hCAFEF00D, 1, 1, 0, 4'b0000, 32'h0, 32'hCAFEF00D, 0);
    vt[8]  = mk(OP_ST,  SZ_W, 32'h7004, 32'h11223344, 32'h0, 0, 1, 1, 4'b1111, 32'h11223344, 32'h0, 0);
    vt[9]  = mk(OP_ST,  SZ_H, 32'h2001, 32'h1111, 32'h0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 1);
    vt[10] = mk(OP_LDU, SZ_B, 32'h8002, 32'h0, 32'h00FF0000, 0, 1, 0, 4'b0000, 32'h0, 32'hFF, 0);
    vt[11] = mk(OP_ALU, SZ_W, 32'h3001, 32'h0, 32'h0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 0);
    vt[12] = mk(OP_LL,  SZ_W, 32'h4000, 32'h0, 32'h99, 0, 1, 0, 4'b0000, 32'h0, 32'h99, 0);
    vt[13] = mk(OP_SC,  SZ_W, 32'h4000, 32'h77, 32'h0, 0, 1, 1, 4'b1111, 32'h77, 32'h1, 0);
    vt[14] = mk(OP_SC,  SZ_W, 32'h4000, 32'h88, 32'h0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 0);
    vt[15] = mk(OP_LD,  SZ_H, 32'h6001, 32'h0, 32'h0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 1);

    reset = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_access_sz = '0; ex_addr = '0; ex_wdata = '0;
    ex_reg_d = '0; ex_exe_out = '0; wb_allowin = 1'b1;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_allowin", {31'b0, mem_allowin}, 32'd1);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_req", {31'b0, data_sram_req}, 32'd0);
    chk("rst_wr", {31'b0, data_sram_wr}, 32'd0);
    chk("rst_size", {30'b0, data_sram_size}, 32'd0);
    chk("rst_wstrb", {28'b0, data_sram_wstrb}, 32'd0);
    chk("rst_addr", data_sram_addr, 32'd0);
    chk("rst_wdata", data_sram_wdata, 32'd0);
    chk("rst_wb_rdata", wb_rdata, 32'd0);
    chk("rst_wb_ale", {31'b0, wb_ale}, 32'd0);
    chk("rst_wb_op", {24'b0, wb_op}, 32'd0);
    chk("rst_wb_sz", {30'b0, wb_mm_access_sz}, 32'd0);
    chk("rst_wb_reg_d", {27'b0, wb_reg_d}, 32'd0);
    chk("rst_wb_exe_out", wb_exe_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      do_op(vt[i], 5'(i + 1), 32'hE000_0000 + 32'(i));

    // Result held while writeback stalls; next op accepted on the handoff cycle.
    v1 = mk(OP_LD, SZ_W, 32'h100, 32'h0, 32'hAAAA0001, 0, 1, 0, 4'b0000, 32'h0, 32'hAAAA0001, 0);
    v2 = mk(OP_LD, SZ_B, 32'h105, 32'h0, 32'h00005500, 0, 1, 0, 4'b0000, 32'h0, 32'h55, 0);
    drive_ex(v1, 5'd20, 32'h0BAD_0001, 1'b1);
    @(posedge clk); #1;
    wb_allowin = 1'b0;
    after_accept(v1);
    drive_ex(v2, 5'd21, 32'h0BAD_0002, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("hold_allowin", {31'b0, mem_allowin}, 32'd0);
      chk("hold_wb_rdata", wb_rdata, 32'hAAAA0001);
      chk("hold_wb_reg_d", {27'b0, wb_reg_d}, 32'd20);
      chk("hold_req", {31'b0, data_sram_req}, 32'd0);
    end
    @(posedge clk); #1;
    wb_allowin = 1'b1;
    @(negedge clk);
    chk("handoff_allowin", {31'b0, mem_allowin}, 32'd1);
    @(posedge clk); #1;
    after_accept(v2);
    @(posedge clk); #1;

    // Reset while waiting for data_ok; the late response must not complete the LL.
    v1 = mk(OP_LL, SZ_W, 32'h4100, 32'h0, 32'h1234, 0, 1, 0, 4'b0000, 32'h0, 32'h1234, 0);
    drive_ex(v1, 5'd22, 32'h0, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    chk("rr_req", {31'b0, data_sram_req}, 32'd1);
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234;
    @(negedge clk);
    chk("rr_req_low", {31'b0, data_sram_req}, 32'd0);
    chk("rr_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rr_allowin", {31'b0, mem_allowin}, 32'd1);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk("rr_wb_valid2", {31'b0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    v2 = mk(OP_SC, SZ_W, 32'h4100, 32'h5, 32'h0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 0);
    do_op(v2, 5'd23, 32'h0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
